// File: rtl/noc_ni_pkg.sv
// Shared types and sizing helpers for the noc_ni network interface.
package noc_ni_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 28;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] data;
  } flit_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cred_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// Show-ahead FIFO with explicit pointer wrap, so any depth >= 1 works.
module ni_rx_fifo
  import noc_ni_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [cred_width(DEPTH)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = cred_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != NW'(0));
    do_push = push_i && ((count_q != FULL) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      wr_d = (wr_q == LAST) ? PW'(0) : wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop) begin
      rd_d = (rd_q == LAST) ? PW'(0) : rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (count_q == FULL);
  assign empty_o = (count_q == NW'(0));
  assign count_o = count_q;

endmodule

// File: rtl/noc_ni.sv
// Network interface between a core and a router local port (credit-based TX, FIFO-buffered RX).
// Define NOC_NI_ERR_CHECK_EN to enable the sticky protocol-error flag err_o.
module noc_ni
  import noc_ni_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CREDITS  = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  input  logic [ADDR_W-1:0]        tx_dest_i,
  input  logic [DATA_W-1:0]        tx_data_i,
  output logic [ADDR_W+DATA_W-1:0] local_o,
  output logic                     valid_l_o,
  input  logic                     l_incr_i,
  input  logic [ADDR_W+DATA_W-1:0] local_i,
  input  logic                     valid_l_i,
  output logic                     l_incr_o,
  output logic                     rx_valid_o,
  input  logic                     rx_ready_i,
  output logic [ADDR_W-1:0]        rx_dest_o,
  output logic [DATA_W-1:0]        rx_data_o,
  output logic                     err_o
);

  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = cred_width(CREDITS);
  localparam int NW = cred_width(RX_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [CW-1:0] cred_q, cred_d;
  logic [FW-1:0] local_q, local_d;
  logic          valid_q, valid_d;
  logic          l_incr_q, l_incr_d;
  logic          accept, rx_pop, rx_push, rx_full, rx_empty;
  logic          tx_overflow, rx_overflow;
  logic [FW-1:0] rx_head;
  logic [NW-1:0] rx_count;

  always_comb begin
    accept      = tx_valid_i && (cred_q != CW'(0));
    rx_pop      = !rx_empty && rx_ready_i;
    rx_push     = valid_l_i && (!rx_full || rx_pop);
    tx_overflow = l_incr_i && !accept && (cred_q == CRED_MAX);
    rx_overflow = valid_l_i && rx_full && !rx_pop;
    l_incr_d    = rx_pop;
    valid_d     = accept;
    if (accept) begin
      local_d = {tx_dest_i, tx_data_i};
    end else begin
      local_d = local_q;
    end
    // A credit arriving with the counter already full is dropped (saturation).
    case ({accept, l_incr_i})
      2'b10:   cred_d = cred_q - CW'(1);
      2'b01:   cred_d = (cred_q == CRED_MAX) ? cred_q : cred_q + CW'(1);
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_q   <= CRED_MAX;
      local_q  <= '0;
      valid_q  <= 1'b0;
      l_incr_q <= 1'b0;
    end else begin
      cred_q   <= cred_d;
      local_q  <= local_d;
      valid_q  <= valid_d;
      l_incr_q <= l_incr_d;
    end
  end

`ifdef NOC_NI_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || tx_overflow || rx_overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_ovf;
  assign unused_ovf = tx_overflow ^ rx_overflow;
  assign err_o      = 1'b0;
`endif

  ni_rx_fifo #(.W(FW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (rx_push),
    .pop_i  (rx_pop),
    .din_i  (local_i),
    .dout_o (rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(rx_count)
  );

  assign tx_ready_o             = (cred_q != CW'(0));
  assign local_o                = local_q;
  assign valid_l_o              = valid_q;
  assign l_incr_o               = l_incr_q;
  assign rx_valid_o             = (rx_count != NW'(0));
  assign {rx_dest_o, rx_data_o} = rx_head;

endmodule

// File: tb/tb_noc_ni.sv
// Directed self-checking bench for noc_ni (RX_DEPTH=4 instance plus an RX_DEPTH=3 wrap instance).
module tb_noc_ni;
  import noc_ni_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid, tx_ready, valid_l_o, l_incr_i, valid_l_i, l_incr_o;
  logic        rx_valid, rx_ready, err;
  logic [3:0]  tx_dest, rx_dest;
  logic [27:0] tx_data, rx_data;
  logic [31:0] local_o, local_i;

  logic        valid_l_i3, rx_ready3, l_incr_o3, rx_valid3, err3, tx_ready3, valid_l_o3;
  logic [3:0]  rx_dest3;
  logic [27:0] rx_data3;
  logic [31:0] local_i3, local_o3;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err;
  flit_t f;

  always #5 clk = ~clk;

  noc_ni #(.ADDR_W(4), .DATA_W(28), .CREDITS(4), .RX_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_dest_i(tx_dest), .tx_data_i(tx_data), .local_o(local_o), .valid_l_o(valid_l_o),
    .l_incr_i(l_incr_i), .local_i(local_i), .valid_l_i(valid_l_i), .l_incr_o(l_incr_o),
    .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_dest_o(rx_dest), .rx_data_o(rx_data),
    .err_o(err)
  );

  noc_ni #(.ADDR_W(4), .DATA_W(28), .CREDITS(4), .RX_DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .tx_valid_i(1'b0), .tx_ready_o(tx_ready3),
    .tx_dest_i(4'h0), .tx_data_i(28'h0), .local_o(local_o3), .valid_l_o(valid_l_o3),
    .l_incr_i(1'b0), .local_i(local_i3), .valid_l_i(valid_l_i3), .l_incr_o(l_incr_o3),
    .rx_valid_o(rx_valid3), .rx_ready_i(rx_ready3), .rx_dest_o(rx_dest3), .rx_data_o(rx_data3),
    .err_o(err3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef NOC_NI_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; tx_valid = 1'b0; tx_dest = 4'h0; tx_data = 28'h0; l_incr_i = 1'b0;
    valid_l_i = 1'b0; local_i = 32'h0; rx_ready = 1'b0;
    valid_l_i3 = 1'b0; local_i3 = 32'h0; rx_ready3 = 1'b0;
    tick(); tick();
    check("rst_valid_l", {63'd0, valid_l_o}, 64'd0);
    check("rst_local", {32'd0, local_o}, 64'd0);
    check("rst_l_incr", {63'd0, l_incr_o}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_tx_ready", {63'd0, tx_ready}, 64'd1);
    check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    rst = 1'b0;
    tick();
    check("tx_ready_after_rst", {63'd0, tx_ready}, 64'd1);

    // TX credit exhaustion: four back-to-back flits then stall
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_dest = 4'(k + 1);
      tx_data = 28'(256 + k);
      tick();
      check("tx_burst_valid", {63'd0, valid_l_o}, 64'd1);
      f.dest = 4'(k + 1); f.data = 28'(256 + k);
      check("tx_burst_flit", {32'd0, local_o}, {32'd0, f});
    end
    check("tx_exhausted", {63'd0, tx_ready}, 64'd0);
    tick();
    check("tx_stall_valid", {63'd0, valid_l_o}, 64'd0);
    check("tx_stall_hold", {32'd0, local_o}, 64'h4000_0103);
    l_incr_i = 1'b1; tx_dest = 4'hA; tx_data = 28'h0ABCDEF;
    tick();
    l_incr_i = 1'b0;
    check("credit_ready", {63'd0, tx_ready}, 64'd1);
    check("credit_no_flit_yet", {63'd0, valid_l_o}, 64'd0);
    tick();
    check("credit_flit_valid", {63'd0, valid_l_o}, 64'd1);
    check("credit_flit", {32'd0, local_o}, 64'hA0AB_CDEF);
    check("credit_reexhaust", {63'd0, tx_ready}, 64'd0);
    tx_valid = 1'b0;

    // Simultaneous accept and credit return with cred=2
    l_incr_i = 1'b1;
    tick(); tick();
    tx_valid = 1'b1;
    tick();
    l_incr_i = 1'b0;
    check("simul_valid", {63'd0, valid_l_o}, 64'd1);
    tick();
    check("simul_cred1", {63'd0, tx_ready}, 64'd1);
    tick();
    check("simul_cred0", {63'd0, tx_ready}, 64'd0);
    tx_valid = 1'b0;

    // Credit overflow: five returns, counter saturates at 4
    l_incr_i = 1'b1;
    repeat (5) tick();
    l_incr_i = 1'b0;
    check("tx_ovf_err", {63'd0, err}, {63'd0, exp_err});
    tx_valid = 1'b1;
    repeat (4) tick();
    check("tx_sat_exhausted", {63'd0, tx_ready}, 64'd0);
    tick();
    check("tx_sat_no_fifth", {63'd0, valid_l_o}, 64'd0);

    // Reset in the middle of traffic
    l_incr_i = 1'b1;
    tick();
    l_incr_i = 1'b0; valid_l_i = 1'b1; local_i = 32'h1234_5678;
    tick();
    valid_l_i = 1'b0;
    check("mid_valid_l", {63'd0, valid_l_o}, 64'd1);
    check("mid_rx_valid", {63'd0, rx_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid_l", {63'd0, valid_l_o}, 64'd0);
    check("mid_rst_local", {32'd0, local_o}, 64'd0);
    check("mid_rst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("mid_rst_err", {63'd0, err}, 64'd0);
    tx_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_ready", {63'd0, tx_ready}, 64'd1);

    // RX fill with the core stalled, then overflow attempt
    for (int k = 1; k <= 4; k++) begin
      valid_l_i = 1'b1;
      local_i = {4'(k), 28'(k)};
      tick();
      check("rx_fill_valid", {63'd0, rx_valid}, 64'd1);
      check("rx_fill_head", {36'd0, rx_data}, 64'd1);
    end
    valid_l_i = 1'b0;
    check("rx_fill_no_credit", {63'd0, l_incr_o}, 64'd0);
    valid_l_i = 1'b1; local_i = {4'd5, 28'd5};
    tick();
    valid_l_i = 1'b0;
    check("rx_ovf_err", {63'd0, err}, {63'd0, exp_err});
    check("rx_ovf_head", {36'd0, rx_data}, 64'd1);
    rx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("rx_drain_data", {36'd0, rx_data}, 64'(k));
      check("rx_drain_dest", {60'd0, rx_dest}, 64'(k));
      tick();
      check("rx_drain_credit", {63'd0, l_incr_o}, 64'd1);
    end
    check("rx_drained_empty", {63'd0, rx_valid}, 64'd0);
    rx_ready = 1'b0;
    tick();
    check("rx_credit_ends", {63'd0, l_incr_o}, 64'd0);
    check("rx_err_sticky", {63'd0, err}, {63'd0, exp_err});

    // RX_DEPTH=3 wrap: ten flits streamed at one per cycle
    rx_ready3 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      valid_l_i3 = 1'b1;
      local_i3 = {4'(k), 28'(80 + k)};
      tick();
      check("wrap_valid", {63'd0, rx_valid3}, 64'd1);
      check("wrap_data", {36'd0, rx_data3}, 64'(80 + k));
      check("wrap_dest", {60'd0, rx_dest3}, 64'(k));
      if (k > 0) check("wrap_credit", {63'd0, l_incr_o3}, 64'd1);
    end
    valid_l_i3 = 1'b0;
    tick();
    check("wrap_empty", {63'd0, rx_valid3}, 64'd0);
    check("wrap_last_credit", {63'd0, l_incr_o3}, 64'd1);
    tick();
    check("wrap_credit_ends", {63'd0, l_incr_o3}, 64'd0);
    check("wrap_no_err", {63'd0, err3}, 64'd0);

    rst = 1'b1;
    tick();
    check("final_rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
